// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared CPU constants: hazard FSM states and stall cause codes
package hazard_ctrl_pkg;

  typedef enum logic [2:0] {
    INIT   = 3'd0,
    RUN    = 3'd1,
    LSTALL = 3'd2,
    SSTALL = 3'd3,
    MWAIT  = 3'd4
  } hazState_t;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_LOADUSE = 2'd1;
  localparam logic [1:0] CAUSE_STRUCT  = 2'd2;
  localparam logic [1:0] CAUSE_MEMWAIT = 2'd3;

  function automatic logic [1:0] causeOf(input hazState_t st);
    case (st)
      LSTALL:  causeOf = CAUSE_LOADUSE;
      SSTALL:  causeOf = CAUSE_STRUCT;
      MWAIT:   causeOf = CAUSE_MEMWAIT;
      default: causeOf = CAUSE_NONE;
    endcase
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use comparator between ID sources and EX load destination
module hazard_detect (
  input  logic [2:0] idRx,
  input  logic [2:0] idRy,
  input  logic       idUseRx,
  input  logic       idUseRy,
  input  logic [1:0] exMemRead,
  input  logic       exRegWrite,
  input  logic [2:0] exDstReg,
  output logic       loadUse
);

  logic isLoad;
  logic rxHit;
  logic ryHit;

  // Register 0 is an ordinary register here, so no zero-register exclusion.
  assign isLoad  = (exMemRead != 2'd0) && exRegWrite;
  assign rxHit   = idUseRx && (idRx == exDstReg);
  assign ryHit   = idUseRy && (idRy == exDstReg);
  assign loadUse = isLoad && (rxHit || ryHit);

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller: freezes, flushes, bubbles and stall counters
module hazard_ctrl
  import hazard_ctrl_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic [2:0]  idRx,
  input  logic [2:0]  idRy,
  input  logic        idUseRx,
  input  logic        idUseRy,
  input  logic [1:0]  exMemRead,
  input  logic        exRegWrite,
  input  logic [2:0]  exDstReg,
  input  logic        redirect,
  input  logic        memConflict,
  input  logic        memBusy,
  output logic        pcFreeze,
  output logic        ifidFreeze,
  output logic        idexFreeze,
  output logic        exmemFreeze,
  output logic        ifidFlush,
  output logic        ctrlZero,
  output logic [1:0]  stallCause,
  output logic [15:0] stallCycles,
  output logic [15:0] flushCount
);

  hazState_t state;
  hazState_t nextState;
  logic      loadUse;
  logic      redirectFlush;

  hazard_detect uDetect (
    .idRx       (idRx),
    .idRy       (idRy),
    .idUseRx    (idUseRx),
    .idUseRy    (idUseRy),
    .exMemRead  (exMemRead),
    .exRegWrite (exRegWrite),
    .exDstReg   (exDstReg),
    .loadUse    (loadUse)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= INIT;
      stallCycles <= 16'd0;
      flushCount  <= 16'd0;
    end else begin
      state <= nextState;
      if (pcFreeze)
        stallCycles <= stallCycles + 16'd1;
      if (redirectFlush)
        flushCount <= flushCount + 16'd1;
    end
  end

  // While RST is high the outputs look like INIT, whatever state was left behind.
  always_comb begin
    pcFreeze      = 1'b0;
    ifidFreeze    = 1'b0;
    idexFreeze    = 1'b0;
    exmemFreeze   = 1'b0;
    ifidFlush     = 1'b0;
    ctrlZero      = 1'b0;
    redirectFlush = 1'b0;
    nextState     = RUN;
    if (RST || state == INIT) begin
      ifidFlush = 1'b1;
      ctrlZero  = 1'b1;
    end else if (memBusy) begin
      pcFreeze    = 1'b1;
      ifidFreeze  = 1'b1;
      idexFreeze  = 1'b1;
      exmemFreeze = 1'b1;
      nextState   = MWAIT;
    end else if (redirect) begin
      ifidFlush     = 1'b1;
      ctrlZero      = 1'b1;
      redirectFlush = 1'b1;
    end else if (loadUse) begin
      pcFreeze   = 1'b1;
      ifidFreeze = 1'b1;
      ctrlZero   = 1'b1;
      nextState  = LSTALL;
    end else if (memConflict) begin
      pcFreeze  = 1'b1;
      ifidFlush = 1'b1;
      nextState = SSTALL;
    end
  end

  assign stallCause = causeOf(state);

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - table-driven bench for hazard_ctrl
module tb_hazard_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [2:0]  idRx = 3'd0, idRy = 3'd0;
  logic        idUseRx = 1'b0, idUseRy = 1'b0;
  logic [1:0]  exMemRead = 2'd0;
  logic        exRegWrite = 1'b0;
  logic [2:0]  exDstReg = 3'd0;
  logic        redirect = 1'b0, memConflict = 1'b0, memBusy = 1'b0;
  logic        pcFreeze, ifidFreeze, idexFreeze, exmemFreeze, ifidFlush, ctrlZero;
  logic [1:0]  stallCause;
  logic [15:0] stallCycles, flushCount;

  int nVec = 0;
  int nErr = 0;

  always #5 CLK = ~CLK;

  hazard_ctrl dut (
    .CLK(CLK), .RST(RST), .idRx(idRx), .idRy(idRy), .idUseRx(idUseRx), .idUseRy(idUseRy),
    .exMemRead(exMemRead), .exRegWrite(exRegWrite), .exDstReg(exDstReg),
    .redirect(redirect), .memConflict(memConflict), .memBusy(memBusy),
    .pcFreeze(pcFreeze), .ifidFreeze(ifidFreeze), .idexFreeze(idexFreeze),
    .exmemFreeze(exmemFreeze), .ifidFlush(ifidFlush), .ctrlZero(ctrlZero),
    .stallCause(stallCause), .stallCycles(stallCycles), .flushCount(flushCount)
  );

  typedef struct {
    logic        rst;
    logic [2:0]  rx;
    logic [2:0]  ry;
    logic        urx;
    logic        ury;
    logic [1:0]  mr;
    logic        rw;
    logic [2:0]  dst;
    logic        redir;
    logic        mc;
    logic        mb;
    logic [5:0]  expOut;   // {pc, ifid, idex, exmem freeze, ifidFlush, ctrlZero}
    logic [1:0]  expCause;
    logic [15:0] expSc;
    logic [15:0] expFc;
  } vec_t;

  vec_t vecs[26];

  function automatic logic [5:0] outBits();
    return {pcFreeze, ifidFreeze, idexFreeze, exmemFreeze, ifidFlush, ctrlZero};
  endfunction

  task automatic drive(input vec_t v);
    RST = v.rst; idRx = v.rx; idRy = v.ry; idUseRx = v.urx; idUseRy = v.ury;
    exMemRead = v.mr; exRegWrite = v.rw; exDstReg = v.dst;
    redirect = v.redir; memConflict = v.mc; memBusy = v.mb;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    //            rst rx ry urx ury mr rw dst rd mc mb  out        cause sc  fc
    vecs[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000011, 0, 0,  0};
    vecs[1]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000011, 0, 0,  0};
    vecs[2]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0,  0};
    vecs[3]  = '{0, 3, 0, 1, 0, 1, 1, 3, 0, 0, 0, 6'b110001, 0, 0,  0};
    vecs[4]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 1, 1,  0};
    vecs[5]  = '{0, 3, 0, 0, 0, 1, 1, 3, 0, 0, 0, 6'b000000, 0, 1,  0};
    vecs[6]  = '{0, 0, 5, 0, 1, 2, 1, 5, 0, 0, 0, 6'b110001, 0, 1,  0};
    vecs[7]  = '{0, 4, 0, 1, 1, 3, 1, 0, 0, 0, 0, 6'b110001, 1, 2,  0};
    vecs[8]  = '{0, 3, 0, 1, 0, 1, 0, 3, 0, 0, 0, 6'b000000, 1, 3,  0};
    vecs[9]  = '{0, 3, 0, 1, 0, 0, 1, 3, 0, 0, 0, 6'b000000, 0, 3,  0};
    vecs[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 6'b100010, 0, 3,  0};
    vecs[11] = '{0, 3, 0, 1, 0, 1, 1, 3, 0, 1, 0, 6'b110001, 2, 4,  0};
    vecs[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 6'b000011, 1, 5,  0};
    vecs[13] = '{0, 3, 0, 1, 0, 1, 1, 3, 1, 0, 0, 6'b000011, 0, 5,  1};
    vecs[14] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 5,  2};
    vecs[15] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 6'b111100, 0, 5,  2};
    vecs[16] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 6'b111100, 3, 6,  2};
    vecs[17] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 6'b111100, 3, 7,  2};
    vecs[18] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 6'b111100, 3, 8,  2};
    vecs[19] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 6'b111100, 3, 9,  2};
    vecs[20] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 6'b000011, 3, 10, 2};
    vecs[21] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 10, 3};
    vecs[22] = '{0, 3, 0, 1, 0, 1, 1, 3, 0, 1, 1, 6'b111100, 0, 10, 3};
    vecs[23] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6'b000011, 3, 11, 3};
    vecs[24] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 6'b000011, 0, 0,  0};
    vecs[25] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0,  0};

    // Two reset edges bring state and counters to a known value before checking.
    RST = 1'b1;
    repeat (2) @(posedge CLK);

    for (int i = 0; i < 26; i++) begin
      @(negedge CLK);
      drive(vecs[i]);
      #1;
      nVec++;
      check($sformatf("v%0d outputs", i), {10'd0, outBits()}, {10'd0, vecs[i].expOut});
      check($sformatf("v%0d stallCause", i), {14'd0, stallCause}, {14'd0, vecs[i].expCause});
      check($sformatf("v%0d stallCycles", i), stallCycles, vecs[i].expSc);
      check($sformatf("v%0d flushCount", i), flushCount, vecs[i].expFc);
    end

    // Counter wrap: 65535 structural stall cycles reach 0xFFFF, one more wraps to 0.
    @(negedge CLK);
    memConflict = 1'b1;
    repeat (65535) @(negedge CLK);
    #1;
    nVec++;
    check("wrap preload stallCycles", stallCycles, 16'hFFFF);
    check("wrap preload pcFreeze", {15'd0, pcFreeze}, 16'd1);
    check("wrap preload stallCause", {14'd0, stallCause}, 16'd2);
    @(negedge CLK);
    memConflict = 1'b0;
    #1;
    nVec++;
    check("wrap stallCycles", stallCycles, 16'h0000);
    check("wrap flushCount", flushCount, 16'h0000);
    check("wrap outputs idle", {10'd0, outBits()}, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have port CLK, input, 1 bit: the single pipeline clock; all state updates on its rising edge.
REQ-002 The block SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-003 The block SHALL have ports idRx and idRy, input, 3 bits each: source register numbers of the instruction in ID.
REQ-004 The block SHALL have ports idUseRx and idUseRy, input, 1 bit each: the ID instruction reads Rx / Ry.
REQ-005 The block SHALL have port exMemRead, input, 2 bits: the EX instruction's memRead field; nonzero means load.
REQ-006 The block SHALL have port exRegWrite, input, 1 bit: the EX instruction writes a general register.
REQ-007 The block SHALL have port exDstReg, input, 3 bits: the EX instruction's resolved destination register.
REQ-008 The block SHALL have port redirect, input, 1 bit: a branch taken or jump resolved in EX.
REQ-009 The block SHALL have port memConflict, input, 1 bit: the MEM stage is accessing instruction RAM this cycle.
REQ-010 The block SHALL have port memBusy, input, 1 bit: the memory/UART controller needs the pipeline held.
REQ-011 The block SHALL have outputs pcFreeze, ifidFreeze, idexFreeze and exmemFreeze, 1 bit each: hold the PC / IF_ID / ID_EX / EX_MEM respectively (1 = hold).
REQ-012 The block SHALL have output ifidFlush, 1 bit: load a NOP into IF_ID.
REQ-013 The block SHALL have output ctrlZero, 1 bit: zero the control inputs to ID_EX, i.e. insert a bubble.
REQ-014 The block SHALL have output stallCause, 2 bits: 0 none, 1 load-use, 2 structural, 3 memory wait.
REQ-015 The block SHALL have outputs stallCycles and flushCount, 16 bits each: performance counters.

Function
REQ-016 State SHALL be one of INIT, RUN, LSTALL, SSTALL, MWAIT, updated on CLK, with Mealy outputs decoded from state plus current inputs.
REQ-017 Per cycle, conditions SHALL be evaluated in priority order memBusy > redirect > load-use > memConflict.
REQ-018 On memBusy=1, all four freezes SHALL be 1, ifidFlush=0, ctrlZero=0, and the next state SHALL be MWAIT.
REQ-019 On redirect=1 with memBusy=0, ifidFlush=1, ctrlZero=1, all freezes=0, and the next state SHALL be RUN.
REQ-020 A load-use hazard SHALL be detected when exMemRead!=0, exRegWrite=1, and ((idUseRx and idRx==exDstReg) or (idUseRy and idRy==exDstReg)).
REQ-021 On load-use with no higher-priority condition, pcFreeze=1, ifidFreeze=1, ctrlZero=1, idexFreeze=0, exmemFreeze=0, and the next state SHALL be LSTALL.
REQ-022 On memConflict with no higher-priority condition, pcFreeze=1, ifidFlush=1, other freezes=0, ctrlZero=0, and the next state SHALL be SSTALL.
REQ-023 With no condition active, all outputs SHALL be 0 and the next state SHALL be RUN; LSTALL, SSTALL and MWAIT each SHALL last exactly as long as their cause.
REQ-024 In INIT (first cycle after reset), ifidFlush=1, ctrlZero=1, freezes=0, and the next state SHALL be RUN unconditionally.
REQ-025 stallCause SHALL equal the encoding of the current registered state (INIT and RUN -> 0).
REQ-026 stallCycles SHALL increment by 1 in every cycle in which pcFreeze=1, wrapping 0xFFFF->0x0000.
REQ-027 flushCount SHALL increment by 1 in every cycle in which ifidFlush=1 due to redirect (not INIT, not memConflict), with the same wrap.
REQ-028 Register number 0 SHALL be compared like any other; no special case applies.

Reset
REQ-029 While RST=1 at a rising CLK edge, state SHALL become INIT and stallCycles and flushCount SHALL become 0.
REQ-030 Reset SHALL override any in-progress stall, including MWAIT, on that same edge.
REQ-031 Outputs SHALL be driven only through the INIT decode while RST is high.

Structure
REQ-032 State encodings and stallCause codes SHALL reside in the shared CPU constants package.
REQ-033 The block SHALL contain one sub-module, hazard_detect: combinational load-use comparator producing a single loadUse bit.

Verification
REQ-034 Load-use: exMemRead=1, exRegWrite=1, exDstReg=3, idUseRx=1, idRx=3 for 1 cycle -> pcFreeze=ifidFreeze=ctrlZero=1, stallCause=1 next cycle, stallCycles +1.
REQ-035 Same as REQ-034 but idUseRx=0 -> no stall; all outputs 0.
REQ-036 memBusy=1 for 5 cycles with redirect=1 held -> all freezes=1 for 5 cycles, then one cycle with ifidFlush=1, ctrlZero=1; flushCount +1, stallCycles +5.
REQ-037 redirect=1 together with memConflict=1 -> redirect wins: ifidFlush=1, ctrlZero=1, pcFreeze=0.
REQ-038 Preload stallCycles to 0xFFFF via 65535 stall cycles, then one more stall -> stallCycles=0x0000.
REQ-039 Assert RST during MWAIT with memBusy=1 -> next cycle state INIT, ifidFlush=1, counters=0, freezes=0.
